// File: rtl/hvac_drive_if.sv
// Request/contactor bundle between the acsystem controller (master) and hvac_drive (slave).
// run_count is present only when HVAC_RUNTIME_EN is defined.
interface hvac_drive_if;
  logic       heating;
  logic       cooling;
  logic       heater_on;
  logic       compressor_on;
  logic       fan_on;
  logic [2:0] state;
  logic       conflict;
`ifdef HVAC_RUNTIME_EN
  logic [15:0] run_count;

  modport master (output heating, cooling,
                  input  heater_on, compressor_on, fan_on, state, conflict, run_count);
  modport slave  (input  heating, cooling,
                  output heater_on, compressor_on, fan_on, state, conflict, run_count);
`else
  modport master (output heating, cooling,
                  input  heater_on, compressor_on, fan_on, state, conflict);
  modport slave  (input  heating, cooling,
                  output heater_on, compressor_on, fan_on, state, conflict);
`endif
endinterface

// File: rtl/hvac_drive.sv
// HVAC contactor driver with min-on, fan overrun and min-off lockout; outputs follow a request 1 edge later.
// No backpressure: requests are sampled every edge. Optional run_count output under HVAC_RUNTIME_EN.
module hvac_drive #(
  parameter int MIN_ON      = 8,
  parameter int FAN_OVERRUN = 4,
  parameter int MIN_OFF     = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  hvac_drive_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEAT    = 3'd1,
    COOL    = 3'd2,
    OVERRUN = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] FO_LAST  = CNT_W'(FAN_OVERRUN - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q;
  logic             conflict_q;
  logic             req_heat, req_cool;

  // Simultaneous heat and cool requests are treated as no request at all.
  assign req_heat = bus.heating & ~bus.cooling;
  assign req_cool = bus.cooling & ~bus.heating;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_heat)      state_d = HEAT;
        else if (req_cool) state_d = COOL;
      end
      HEAT:    if (!req_heat && timer_q >= ON_LAST) state_d = OVERRUN;
      COOL:    if (!req_cool && timer_q >= ON_LAST) state_d = OVERRUN;
      OVERRUN: if (timer_q == FO_LAST)  state_d = LOCKOUT;
      LOCKOUT: if (timer_q == OFF_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      conflict_q <= bus.heating & bus.cooling;
      if (state_d != state_q)    timer_q <= '0;
      else if (timer_q != CNT_MAX) timer_q <= timer_q + 1'b1;
    end
  end

  assign bus.heater_on     = (state_q == HEAT);
  assign bus.compressor_on = (state_q == COOL);
  assign bus.fan_on        = (state_q == HEAT) || (state_q == COOL) || (state_q == OVERRUN);
  assign bus.state         = state_q;
  assign bus.conflict      = conflict_q;

`ifdef HVAC_RUNTIME_EN
  logic [15:0] run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else if ((state_d == HEAT || state_d == COOL) && run_q != 16'hFFFF) begin
      run_q <= run_q + 16'd1;
    end
  end

  assign bus.run_count = run_q;
`endif

endmodule

// File: tb/tb_hvac_drive.sv
// Directed vector table plus hand-written sequences for timer saturation and reset during lockout.
module tb_hvac_drive;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hvac_drive_if bus ();

  hvac_drive #(.MIN_ON(8), .FAN_OVERRUN(4), .MIN_OFF(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         grp;
    logic       r, h, c;
    logic       heater, comp, fan;
    logic [2:0] st;
    logic       conf;
  } vec_t;

  vec_t vecs[$];
  int   cur_grp = 0;
  int   total   = 0;
  int   bad     = 0;

  task automatic push(int n, logic r, logic h, logic c,
                      logic hr, logic cp, logic fn, logic [2:0] st, logic cf);
    vec_t v;
    v.grp = cur_grp; v.r = r; v.h = h; v.c = c;
    v.heater = hr; v.comp = cp; v.fan = fn; v.st = st; v.conf = cf;
    repeat (n) vecs.push_back(v);
  endtask

  // n fan-only cycles, then 8 lockout cycles, then back in IDLE; inputs idle.
  task automatic wind_down(int n);
    push(n, 0, 0, 0, 0, 0, 1, 3'd3, 0);
    push(8, 0, 0, 0, 0, 0, 0, 3'd4, 0);
    push(1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
  endtask

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0d: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(logic r, logic h, logic c);
    rst = r; bus.heating = h; bus.cooling = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.heating = 1'b0; bus.cooling = 1'b0;

    // 1: reset hold with heating high, release, heater runs its minimum.
    cur_grp = 1;
    push(2, 1, 1, 0, 0, 0, 0, 3'd0, 0);
    push(1, 0, 1, 0, 1, 0, 1, 3'd1, 0);
    push(7, 0, 0, 0, 1, 0, 1, 3'd1, 0);
    wind_down(4);
    // 2: one-cycle heat pulse from IDLE.
    cur_grp = 2;
    push(1, 0, 1, 0, 1, 0, 1, 3'd1, 0);
    push(7, 0, 0, 0, 1, 0, 1, 3'd1, 0);
    wind_down(4);
    // 3: long heat, drops on the first edge that samples heating low.
    cur_grp = 3;
    push(20, 0, 1, 0, 1, 0, 1, 3'd1, 0);
    wind_down(4);
    // 4: heat -> cool changeover through overrun and lockout.
    cur_grp = 4;
    push(3, 0, 1, 0, 1, 0, 1, 3'd1, 0);
    push(5, 0, 0, 1, 1, 0, 1, 3'd1, 0);
    push(4, 0, 0, 1, 0, 0, 1, 3'd3, 0);
    push(8, 0, 0, 1, 0, 0, 0, 3'd4, 0);
    push(1, 0, 0, 1, 0, 0, 0, 3'd0, 0);
    push(8, 0, 0, 1, 0, 1, 1, 3'd2, 0);
    wind_down(4);
    // 5: conflicting requests in IDLE.
    cur_grp = 5;
    push(5, 0, 1, 1, 0, 0, 0, 3'd0, 1);
    push(1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    // 6: conflict during HEAT once minimum on-time is met.
    cur_grp = 6;
    push(8, 0, 1, 0, 1, 0, 1, 3'd1, 0);
    push(1, 0, 1, 1, 0, 0, 1, 3'd3, 1);
    wind_down(3);
    // 7: reset in the third COOL cycle, restart without lockout.
    cur_grp = 7;
    push(2, 0, 0, 1, 0, 1, 1, 3'd2, 0);
    push(1, 1, 0, 1, 0, 0, 0, 3'd0, 0);
    push(1, 0, 0, 1, 0, 1, 1, 3'd2, 0);
    push(7, 0, 0, 0, 0, 1, 1, 3'd2, 0);
    wind_down(4);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("g%0d", vecs[i].grp);
      step(vecs[i].r, vecs[i].h, vecs[i].c);
      chk({tag, "_heater"},   i, 32'(bus.heater_on),     32'(vecs[i].heater));
      chk({tag, "_comp"},     i, 32'(bus.compressor_on), 32'(vecs[i].comp));
      chk({tag, "_fan"},      i, 32'(bus.fan_on),        32'(vecs[i].fan));
      chk({tag, "_state"},    i, 32'(bus.state),         32'(vecs[i].st));
      chk({tag, "_conflict"}, i, 32'(bus.conflict),      32'(vecs[i].conf));
      chk({tag, "_overlap"},  i, 32'(bus.heater_on & bus.compressor_on), 32'd0);
    end

    // Timer saturation: 258 heat cycles put the timer past 255; a wrapping
    // timer would read 1 at the drop and wrongly hold HEAT.
    begin
      int held = 0;
      for (int k = 0; k < 258; k++) begin
        step(0, 1, 0);
        if (bus.heater_on === 1'b1 && bus.state === 3'd1) held++;
      end
      chk("sat_hold", 0, 32'(held), 32'd258);
      step(0, 0, 0);
      chk("sat_exit", 0, 32'(bus.state), 32'd3);
      // Reset in the middle of lockout: no remaining lockout is honoured.
      repeat (4) step(0, 0, 0);
      chk("lock_entered", 0, 32'(bus.state), 32'd4);
      step(1, 1, 0);
      chk("lock_rst", 0, 32'({bus.state, bus.fan_on, bus.heater_on}), 32'd0);
      step(0, 1, 0);
      chk("lock_rst_heat", 0, 32'({bus.heater_on, bus.fan_on, bus.state}), 32'b11_001);
      repeat (7) step(0, 0, 0);
      chk("lock_rst_minon", 0, 32'(bus.heater_on), 32'd1);
      step(0, 0, 0);
      chk("lock_rst_ovr", 0, 32'({bus.heater_on, bus.fan_on, bus.state}), 32'b01_011);
      repeat (12) step(0, 0, 0);
      chk("lock_rst_idle", 0, 32'(bus.state), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
